calc1_port_monitor: RTL and testbench

- Per-port transaction monitor on the calc1 output side; one instance per port (four total), fed by the same request bus as the DUV.
- Snoops each command and its two operands, then computes the expected response and data.
- Queues expectations in order and compares each DUV response against the queue head.
- Flags mismatches, unexpected responses, timeouts and queue overflow; keeps pass/error counts for the checker and end-of-test report.

---
 rtl/calc1_port_monitor_if.sv | 12 +
 rtl/calc1_port_monitor.sv | 182 ++++++++++++++++++
 tb/tb_calc1_port_monitor.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/calc1_port_monitor_if.sv
// Snooped calc1 port bus: the request side (command and operand stream)
// and the DUV response side (response code and result data).
interface calc1_port_monitor_if;
  logic [0:3]  req_cmd_in;
  logic [0:31] req_data_in;
  logic [0:1]  out_resp;
  logic [0:31] out_data;

  // The stimulus side drives the bus; the monitor only observes it.
  modport master (output req_cmd_in, output req_data_in, output out_resp, output out_data);
  modport slave  (input  req_cmd_in, input  req_data_in, input  out_resp, input  out_data);
endinterface

// File: rtl/calc1_port_monitor.sv
// calc1 per-port monitor: captures command + two operands, predicts the
// response, queues predictions in order and scores each DUV response
// against the oldest prediction. Also reports unexpected responses,
// head-entry timeouts and expectation-queue overflow.
module calc1_port_monitor #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                c_clk,
  input  logic                reset,
  input  logic                enable,
  calc1_port_monitor_if.slave bus,
  output logic [0:4]          pending,
  output logic                pass,
  output logic                mismatch,
  output logic                unexpected,
  output logic                timeout,
  output logic                overflow,
  output logic [0:15]         pass_count,
  output logic [0:15]         err_count,
  output logic [0:31]         exp_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Age never exceeds TIMEOUT-1: the head is retired on the cycle it would reach TIMEOUT.
  localparam int AGE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [0:4]       DEPTH_C   = 5'(DEPTH);
  localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(TIMEOUT - 1);

  typedef enum logic {ST_IDLE, ST_OP2} state_t;

  state_t            state_q, state_d;
  logic [0:3]        cmd_q, cmd_d;
  logic [0:31]       op1_q, op1_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [0:4]        count_q, count_d;
  logic [AGE_W-1:0]  age_q, age_d;
  logic              pass_q, pass_d, mismatch_q, mismatch_d;
  logic              unexpected_q, unexpected_d, timeout_q, timeout_d;
  logic              overflow_q, overflow_d;
  logic [0:15]       pass_count_q, pass_count_d, err_count_q, err_count_d;

  // Small queue kept in registers so the head is visible in the same cycle.
  logic [0:1]        fifo_resp_q [DEPTH];
  logic [0:31]       fifo_data_q [DEPTH];

  logic              push, push_ok, pop, resp_valid, resp_pop, expire, fifo_empty, matched;
  logic [0:32]       sum;
  logic [0:4]        shamt;
  logic [0:1]        exp_resp;
  logic [0:31]       exp_val, head_data;
  logic [0:1]        head_resp;

  // Predict the DUV response from the latched command/op1 and op2 on the bus.
  always_comb begin
    sum      = {1'b0, op1_q} + {1'b0, bus.req_data_in};
    shamt    = bus.req_data_in[27:31];
    exp_resp = 2'd1;
    exp_val  = '0;
    case (cmd_q)
      4'd1: if (sum[0]) exp_resp = 2'd2; else exp_val = sum[1:32];
      4'd2: if (bus.req_data_in > op1_q) exp_resp = 2'd2; else exp_val = op1_q - bus.req_data_in;
      4'd5: exp_val = op1_q << shamt;
      4'd6: exp_val = op1_q >> shamt;
      default: exp_resp = 2'd3;
    endcase
  end

  // Capture FSM: first beat latches command and op1, second beat pushes the prediction.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    op1_d   = op1_q;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: if (enable && bus.req_cmd_in != 4'd0) begin
        cmd_d   = bus.req_cmd_in;
        op1_d   = bus.req_data_in;
        state_d = ST_OP2;
      end
      ST_OP2: if (enable) begin
        push    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Queue bookkeeping, scoring, timeout ageing and the saturating counters.
  always_comb begin
    fifo_empty = (count_q == 5'd0);
    head_resp  = fifo_resp_q[rd_ptr_q];
    head_data  = fifo_data_q[rd_ptr_q];
    resp_valid = enable && (bus.out_resp != 2'd0);
    resp_pop   = resp_valid && !fifo_empty;
    // A response arriving on the expiry cycle takes precedence over the timeout.
    expire     = enable && !fifo_empty && !resp_valid && (age_q == AGE_LIMIT);
    pop        = resp_pop || expire;
    // A pop in the same cycle frees the slot a push into a full queue needs.
    push_ok    = push && ((count_q != DEPTH_C) || pop);
    matched    = (bus.out_resp == head_resp) &&
                 ((head_resp != 2'd1) || (bus.out_data == head_data));

    pass_d       = resp_pop && matched;
    mismatch_d   = resp_pop && !matched;
    unexpected_d = resp_valid && fifo_empty;
    timeout_d    = expire;
    overflow_d   = overflow_q || (push && !push_ok);

    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase

    if (fifo_empty || pop) age_d = '0;
    else if (enable)       age_d = age_q + 1'b1;
    else                   age_d = age_q;

    pass_count_d = pass_count_q;
    if (pass_d && pass_count_q != 16'hFFFF) pass_count_d = pass_count_q + 16'd1;
    err_count_d = err_count_q;
    if ((mismatch_d || unexpected_d || timeout_d) && err_count_q != 16'hFFFF)
      err_count_d = err_count_q + 16'd1;
  end

  // State, pointer, pulse and counter registers.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      op1_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      age_q        <= '0;
      pass_q       <= 1'b0;
      mismatch_q   <= 1'b0;
      unexpected_q <= 1'b0;
      timeout_q    <= 1'b0;
      overflow_q   <= 1'b0;
      pass_count_q <= '0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      op1_q        <= op1_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      age_q        <= age_d;
      pass_q       <= pass_d;
      mismatch_q   <= mismatch_d;
      unexpected_q <= unexpected_d;
      timeout_q    <= timeout_d;
      overflow_q   <= overflow_d;
      pass_count_q <= pass_count_d;
      err_count_q  <= err_count_d;
    end
  end

  // Expectation storage; entries are only meaningful below count_q, so no reset.
  always_ff @(posedge c_clk) begin
    if (push_ok) begin
      fifo_resp_q[wr_ptr_q] <= exp_resp;
      fifo_data_q[wr_ptr_q] <= exp_val;
    end
  end

  assign pending    = count_q;
  assign pass       = pass_q;
  assign mismatch   = mismatch_q;
  assign unexpected = unexpected_q;
  assign timeout    = timeout_q;
  assign overflow   = overflow_q;
  assign pass_count = pass_count_q;
  assign err_count  = err_count_q;
  assign exp_data   = fifo_empty ? 32'd0 : head_data;

endmodule

// File: tb/tb_calc1_port_monitor.sv
// Self-checking bench for calc1_port_monitor (DEPTH=4, TIMEOUT=8).
module tb_calc1_port_monitor;
  logic        c_clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [0:4]  pending;
  logic        pass, mismatch, unexpected, timeout, overflow;
  logic [0:15] pass_count, err_count;
  logic [0:31] exp_data;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_pass = 0;
  int exp_err  = 0;

  always #5 c_clk = ~c_clk;

  calc1_port_monitor_if bus ();

  calc1_port_monitor #(.DEPTH(4), .TIMEOUT(8)) dut (
    .c_clk(c_clk), .reset(reset), .enable(enable), .bus(bus),
    .pending(pending), .pass(pass), .mismatch(mismatch), .unexpected(unexpected),
    .timeout(timeout), .overflow(overflow), .pass_count(pass_count),
    .err_count(err_count), .exp_data(exp_data)
  );

  // Reference model: expected response/data from plain 64-bit arithmetic.
  function automatic void model(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                output logic [1:0] r, output logic [31:0] d);
    logic [63:0] s;
    r = 2'd1;
    d = 32'd0;
    case (cmd)
      4'd1: begin s = 64'(a) + 64'(b); if (s > 64'h0000_0000_FFFF_FFFF) r = 2'd2; else d = s[31:0]; end
      4'd2: if (b > a) r = 2'd2; else d = a - b;
      4'd5: d = a << (b % 32);
      4'd6: d = a >> (b % 32);
      default: r = 2'd3;
    endcase
  endfunction

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.req_cmd_in = 4'd0; bus.req_data_in = 32'd0; bus.out_resp = 2'd0; bus.out_data = 32'd0;
  endtask

  // Two-beat command; a junk command in the second beat must be ignored.
  task automatic issue(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    bus.req_cmd_in = cmd; bus.req_data_in = a; tick();
    bus.req_cmd_in = 4'hF; bus.req_data_in = b; tick();
    bus.req_cmd_in = 4'd0; bus.req_data_in = 32'd0;
  endtask

  task automatic respond(input logic [1:0] r, input logic [31:0] d);
    bus.out_resp = r; bus.out_data = d; tick();
    bus.out_resp = 2'd0; bus.out_data = 32'd0;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; drive_idle();
    tick(); tick();
    n_assert++; if ({pass, mismatch, unexpected, timeout, overflow} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 00000", {pass, mismatch, unexpected, timeout, overflow}); end
    n_assert++; if (pending !== 5'd0 || exp_data !== 32'd0) begin n_fail++; $display("FAIL reset_fifo: pending=%0d exp_data=%h expected 0/0", pending, exp_data); end
    n_assert++; if (pass_count !== 16'd0 || err_count !== 16'd0) begin n_fail++; $display("FAIL reset_counts: pass=%0d err=%0d expected 0/0", pass_count, err_count); end
    reset = 1'b1; enable = 1'b1; tick();
    $display("test_reset done");
  endtask

  task automatic test_add();
    issue(4'd1, 32'd5, 32'd3);
    n_assert++; if (pending !== 5'd1 || exp_data !== 32'd8) begin n_fail++; $display("FAIL add_queued: pending=%0d exp_data=%0d expected 1/8", pending, exp_data); end
    respond(2'd1, 32'd8); exp_pass++;
    n_assert++; if (pass !== 1'b1 || mismatch !== 1'b0) begin n_fail++; $display("FAIL add_pass: pass=%b mismatch=%b expected 1/0", pass, mismatch); end
    n_assert++; if (pass_count !== 16'(exp_pass) || pending !== 5'd0) begin n_fail++; $display("FAIL add_count: pass_count=%0d pending=%0d expected %0d/0", pass_count, pending, exp_pass); end
    tick();
    n_assert++; if (pass !== 1'b0) begin n_fail++; $display("FAIL add_pulse_width: pass=%b expected 0", pass); end
    $display("test_add: 5+3 resp 1 data 8 pass=1");
  endtask

  task automatic test_add_overflow();
    issue(4'd1, 32'hFFFF_FFFF, 32'd1);
    respond(2'd2, 32'd0); exp_pass++;
    n_assert++; if (pass !== 1'b1) begin n_fail++; $display("FAIL addovf_pass: pass=%b expected 1", pass); end
    issue(4'd1, 32'hFFFF_FFFF, 32'd1);
    respond(2'd1, 32'd0); exp_err++;
    n_assert++; if (mismatch !== 1'b1 || pass !== 1'b0) begin n_fail++; $display("FAIL addovf_mismatch: mismatch=%b pass=%b expected 1/0", mismatch, pass); end
    n_assert++; if (err_count !== 16'(exp_err)) begin n_fail++; $display("FAIL addovf_err_count: err_count=%0d expected %0d", err_count, exp_err); end
    $display("test_add_overflow: carry case scored resp2 pass, resp1 mismatch");
  endtask

  task automatic test_sub_shift_invalid();
    logic [3:0]  cmds [4] = '{4'd2, 4'd5, 4'd4, 4'd6};
    logic [31:0] as   [4] = '{32'd3, 32'd1, 32'd7, 32'h8000_0000};
    logic [31:0] bs   [4] = '{32'd5, 32'h21, 32'd9, 32'd31};
    logic [1:0]  rs   [4] = '{2'd2, 2'd1, 2'd3, 2'd1};
    logic [31:0] ds   [4] = '{32'hDEAD_BEEF, 32'd2, 32'h1234_5678, 32'd1};
    for (int i = 0; i < 4; i++) begin
      issue(cmds[i], as[i], bs[i]);
      respond(rs[i], ds[i]); exp_pass++;
      n_assert++; if (pass !== 1'b1 || pass_count !== 16'(exp_pass)) begin n_fail++; $display("FAIL sub_shift_invalid[%0d]: pass=%b pass_count=%0d expected 1/%0d", i, pass, pass_count, exp_pass); end
      $display("test_sub_shift_invalid: cmd %0d resp %0d pass=%b", cmds[i], rs[i], pass);
    end
  endtask

  task automatic test_unexpected();
    respond(2'd1, 32'd0); exp_err++;
    n_assert++; if (unexpected !== 1'b1 || pending !== 5'd0) begin n_fail++; $display("FAIL unexpected: unexpected=%b pending=%0d expected 1/0", unexpected, pending); end
    n_assert++; if (err_count !== 16'(exp_err)) begin n_fail++; $display("FAIL unexpected_err_count: err_count=%0d expected %0d", err_count, exp_err); end
    $display("test_unexpected: unexpected=%b", unexpected);
  endtask

  task automatic test_timeout();
    issue(4'd1, 32'd10, 32'd20);
    for (int k = 1; k <= 9; k++) begin
      tick();
      n_assert++; if (timeout !== (k == 8)) begin n_fail++; $display("FAIL timeout_cycle%0d: timeout=%b expected %b", k, timeout, (k == 8)); end
      n_assert++; if (pending !== ((k < 8) ? 5'd1 : 5'd0)) begin n_fail++; $display("FAIL timeout_pending%0d: pending=%0d expected %0d", k, pending, (k < 8) ? 1 : 0); end
    end
    exp_err++;
    n_assert++; if (err_count !== 16'(exp_err)) begin n_fail++; $display("FAIL timeout_err_count: err_count=%0d expected %0d", err_count, exp_err); end
    $display("test_timeout: head retired 8 cycles after push");
  endtask

  task automatic test_back_to_back();
    issue(4'd1, 32'd100, 32'd200);
    // Next command starts immediately; its second beat coincides with the answer to the first.
    bus.req_cmd_in = 4'd2; bus.req_data_in = 32'd50; tick();
    bus.req_cmd_in = 4'd0; bus.req_data_in = 32'd20; bus.out_resp = 2'd1; bus.out_data = 32'd300; tick();
    drive_idle(); exp_pass++;
    n_assert++; if (pass !== 1'b1 || pending !== 5'd1) begin n_fail++; $display("FAIL b2b_push_pop: pass=%b pending=%0d expected 1/1", pass, pending); end
    respond(2'd1, 32'd30); exp_pass++;
    n_assert++; if (pass !== 1'b1 || pending !== 5'd0) begin n_fail++; $display("FAIL b2b_second: pass=%b pending=%0d expected 1/0", pass, pending); end
    $display("test_back_to_back: push and pop in one cycle kept pending");
  endtask

  task automatic test_random();
    logic [3:0]  c;
    logic [31:0] a, b, dd;
    logic [1:0]  rr, rq [$];
    logic [31:0] dq [$];
    logic [1:0]  r_drv;
    logic [31:0] d_drv;
    logic        corrupt;
    int          sel;
    for (int it = 0; it < 12; it++) begin
      for (int j = 0; j < 2; j++) begin
        sel = $urandom_range(0, 4);
        case (sel)
          0: c = 4'd1;
          1: c = 4'd2;
          2: c = 4'd5;
          3: c = 4'd6;
          default: begin c = 4'($urandom_range(3, 15)); if (c == 4'd5 || c == 4'd6) c = 4'd7; end
        endcase
        a = $urandom; b = $urandom;
        if ($urandom_range(0, 1) == 1) begin a = a >> 16; b = b >> 16; end
        model(c, a, b, rr, dd);
        rq.push_back(rr); dq.push_back(dd);
        issue(c, a, b);
      end
      n_assert++; if (pending !== 5'd2) begin n_fail++; $display("FAIL rand_pending%0d: pending=%0d expected 2", it, pending); end
      if (rq[0] == 2'd1) begin
        n_assert++; if (exp_data !== dq[0]) begin n_fail++; $display("FAIL rand_exp_data%0d: exp_data=%h expected %h", it, exp_data, dq[0]); end
      end
      while (rq.size() > 0) begin
        rr = rq.pop_front(); dd = dq.pop_front();
        repeat ($urandom_range(0, 1)) tick();
        corrupt = ($urandom_range(0, 3) == 0);
        r_drv = rr;
        d_drv = (rr == 2'd1) ? dd : $urandom;
        if (corrupt) begin
          if (rr == 2'd1 && $urandom_range(0, 1) == 1) d_drv = dd ^ (32'd1 << $urandom_range(0, 31));
          else r_drv = (rr == 2'd3) ? 2'd1 : rr + 2'd1;
        end
        respond(r_drv, d_drv);
        if (corrupt) exp_err++; else exp_pass++;
        n_assert++; if (pass !== !corrupt || mismatch !== corrupt) begin n_fail++; $display("FAIL rand_score%0d: pass=%b mismatch=%b expected %b/%b", it, pass, mismatch, !corrupt, corrupt); end
        n_assert++; if (pass_count !== 16'(exp_pass) || err_count !== 16'(exp_err)) begin n_fail++; $display("FAIL rand_counts%0d: pass=%0d err=%0d expected %0d/%0d", it, pass_count, err_count, exp_pass, exp_err); end
        $display("test_random: it %0d resp %0d data %h corrupt=%b pass=%b mismatch=%b", it, r_drv, d_drv, corrupt, pass, mismatch);
      end
    end
  endtask

  task automatic test_overflow_reset();
    for (int i = 0; i < 4; i++) issue(4'd1, 32'(i), 32'd1);
    n_assert++; if (pending !== 5'd4 || overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_full: pending=%0d overflow=%b expected 4/0", pending, overflow); end
    // Fifth command pushes into a full queue while the head is answered on its last waiting cycle.
    bus.req_cmd_in = 4'd1; bus.req_data_in = 32'd40; tick();
    bus.req_cmd_in = 4'd0; bus.req_data_in = 32'd2; bus.out_resp = 2'd1; bus.out_data = 32'd1; tick();
    drive_idle(); exp_pass++;
    n_assert++; if (pass !== 1'b1 || timeout !== 1'b0) begin n_fail++; $display("FAIL ovf_resp_wins: pass=%b timeout=%b expected 1/0", pass, timeout); end
    n_assert++; if (pending !== 5'd4 || overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_full_pop: pending=%0d overflow=%b expected 4/0", pending, overflow); end
    issue(4'd2, 32'd7, 32'd7);
    n_assert++; if (pending !== 5'd4 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_drop: pending=%0d overflow=%b expected 4/1", pending, overflow); end
    // Reset asserted between edges while the capture FSM waits for op2.
    bus.req_cmd_in = 4'd1; bus.req_data_in = 32'd9; tick();
    bus.req_cmd_in = 4'd0; #2; reset = 1'b0; #1;
    exp_pass = 0; exp_err = 0;
    n_assert++; if ({pass, mismatch, unexpected, timeout, overflow} !== 5'b0 || pending !== 5'd0) begin n_fail++; $display("FAIL ovf_async_reset: flags=%b pending=%0d expected 00000/0", {pass, mismatch, unexpected, timeout, overflow}, pending); end
    n_assert++; if (pass_count !== 16'd0 || err_count !== 16'd0 || exp_data !== 32'd0) begin n_fail++; $display("FAIL ovf_reset_counts: pass=%0d err=%0d exp_data=%h expected 0", pass_count, err_count, exp_data); end
    tick(); reset = 1'b1; drive_idle(); tick();
    issue(4'd1, 32'd2, 32'd2);
    respond(2'd1, 32'd4); exp_pass++;
    n_assert++; if (pass !== 1'b1 || pass_count !== 16'(exp_pass) || pending !== 5'd0) begin n_fail++; $display("FAIL ovf_after_reset: pass=%b pass_count=%0d pending=%0d expected 1/%0d/0", pass, pass_count, pending, exp_pass); end
    $display("test_overflow_reset: overflow set then cleared by reset");
  endtask

  initial begin
    test_reset();
    test_add();
    test_add_overflow();
    test_sub_shift_invalid();
    test_unexpected();
    test_timeout();
    test_back_to_back();
    test_random();
    test_overflow_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
